// File: rtl/chunk_adder.sv
// ---------------------------------------------------------------------------
// chunk_adder : multi-cycle WIDTH-bit adder/subtractor, CHUNK bits per clock
// Revision    : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module chunk_adder #(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             mode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             ci,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int N   = WIDTH / CHUNK;
  localparam int CW  = (N > 1) ? $clog2(N) : 1;
  localparam int MSB = WIDTH - 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(N - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic              w_accept;
  logic              w_last;

  logic [WIDTH-1:0]  r_a;
  logic [WIDTH-1:0]  r_b;
  logic              r_carry;
  logic [CW-1:0]     r_cnt;
  logic [WIDTH-1:0]  r_work;
  logic [WIDTH-1:0]  r_sum;
  logic              r_cout;
  logic              r_ovf;

  logic [CHUNK-1:0]  w_a_chunk;
  logic [CHUNK-1:0]  w_b_chunk;
  logic [CHUNK:0]    w_chunk_sum;
  logic [WIDTH-1:0]  w_work_nxt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_last      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_accept    = 1'b1;
          w_state_nxt = S_RUN;
        end
      end
      S_RUN: begin
        if (r_cnt == LAST_CNT) begin
          w_last      = 1'b1;
          w_state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        if (start) begin
          w_accept    = 1'b1;
          w_state_nxt = S_RUN;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // One chunk of the ripple chain per cycle; the carry is the only state
  // that crosses chunk boundaries.
  always_comb begin
    w_a_chunk   = r_a[int'(r_cnt) * CHUNK +: CHUNK];
    w_b_chunk   = r_b[int'(r_cnt) * CHUNK +: CHUNK];
    w_chunk_sum = {1'b0, w_a_chunk} + {1'b0, w_b_chunk} + {{CHUNK{1'b0}}, r_carry};
    w_work_nxt  = r_work;
    w_work_nxt[int'(r_cnt) * CHUNK +: CHUNK] = w_chunk_sum[CHUNK-1:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_a     <= '0;
      r_b     <= '0;
      r_carry <= 1'b0;
      r_cnt   <= '0;
      r_work  <= '0;
      r_sum   <= '0;
      r_cout  <= 1'b0;
      r_ovf   <= 1'b0;
    end else if (w_accept) begin
      // Subtraction is a + ~b + 1: invert b once here and seed the carry.
      r_a     <= a;
      r_b     <= mode ? ~b : b;
      r_carry <= mode ? 1'b1 : ci;
      r_cnt   <= '0;
      r_work  <= '0;
    end else if (r_state == S_RUN) begin
      r_work  <= w_work_nxt;
      r_carry <= w_chunk_sum[CHUNK];
      r_cnt   <= r_cnt + 1'b1;
      if (w_last) begin
        // The last chunk holds the MSB, so its sum bit is the result sign.
        r_sum  <= w_work_nxt;
        r_cout <= w_chunk_sum[CHUNK];
        r_ovf  <= (r_a[MSB] == r_b[MSB]) && (w_chunk_sum[CHUNK-1] != r_a[MSB]);
      end
    end
  end

  assign busy = (r_state == S_RUN);
  assign done = (r_state == S_DONE);
  assign sum  = r_sum;
  assign cout = r_cout;
  assign ovf  = r_ovf;

endmodule

`default_nettype wire

// File: tb/tb_chunk_adder.sv
// ---------------------------------------------------------------------------
// tb_chunk_adder : directed and sweep checks of chunk_adder
// Revision       : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_chunk_adder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, start, mode, ci;
  logic [15:0] a, b;
  logic        busy, done, cout, ovf;
  logic [15:0] sum;

  logic [3:0]  sst, sbusy, sdone, scout, sovf;
  logic        smode, sci;
  logic [31:0] sa, sb;
  logic [3:0]  sum41, sum42, sum44;
  logic [31:0] sum328;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  always @(posedge clk) cyc <= cyc + 1;

  chunk_adder #(.WIDTH(16), .CHUNK(4)) u_dut (
    .clk(clk), .rst(rst), .start(start), .mode(mode), .a(a), .b(b), .ci(ci),
    .busy(busy), .done(done), .sum(sum), .cout(cout), .ovf(ovf));

  chunk_adder #(.WIDTH(4), .CHUNK(1)) u_w4c1 (
    .clk(clk), .rst(rst), .start(sst[0]), .mode(smode), .a(sa[3:0]), .b(sb[3:0]), .ci(sci),
    .busy(sbusy[0]), .done(sdone[0]), .sum(sum41), .cout(scout[0]), .ovf(sovf[0]));

  chunk_adder #(.WIDTH(4), .CHUNK(2)) u_w4c2 (
    .clk(clk), .rst(rst), .start(sst[1]), .mode(smode), .a(sa[3:0]), .b(sb[3:0]), .ci(sci),
    .busy(sbusy[1]), .done(sdone[1]), .sum(sum42), .cout(scout[1]), .ovf(sovf[1]));

  chunk_adder #(.WIDTH(4), .CHUNK(4)) u_w4c4 (
    .clk(clk), .rst(rst), .start(sst[2]), .mode(smode), .a(sa[3:0]), .b(sb[3:0]), .ci(sci),
    .busy(sbusy[2]), .done(sdone[2]), .sum(sum44), .cout(scout[2]), .ovf(sovf[2]));

  chunk_adder #(.WIDTH(32), .CHUNK(8)) u_w32c8 (
    .clk(clk), .rst(rst), .start(sst[3]), .mode(smode), .a(sa), .b(sb), .ci(sci),
    .busy(sbusy[3]), .done(sdone[3]), .sum(sum328), .cout(scout[3]), .ovf(sovf[3]));

  typedef struct packed {
    logic [15:0] a;
    logic [15:0] b;
    logic        ci;
    logic        mode;
    logic [15:0] s;
    logic        c;
    logic        o;
  } vec_t;

  // Behavioural reference: plain integer add/subtract, borrow from compare.
  function automatic void model(input int w, input logic [31:0] ia, ib, input logic ici, imode,
                                output logic [31:0] s, output logic c, o);
    logic [63:0] t;
    logic [63:0] mask;
    mask = (64'd1 << w) - 64'd1;
    if (!imode) begin
      t = {32'd0, ia} + {32'd0, ib} + {63'd0, ici};
      s = t[31:0] & mask[31:0];
      c = t[w];
      o = (ia[w-1] == ib[w-1]) && (s[w-1] != ia[w-1]);
    end else begin
      t = {32'd0, ia} - {32'd0, ib};
      s = t[31:0] & mask[31:0];
      c = (ia >= ib);
      o = (ia[w-1] != ib[w-1]) && (s[w-1] != ia[w-1]);
    end
  endfunction

  task automatic do_op(input logic [15:0] ia, ib, input logic ici, imode,
                       output int ncyc, output bit tmo);
    int guard;
    @(negedge clk);
    a = ia; b = ib; ci = ici; mode = imode; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    ncyc  = 0;
    guard = 0;
    while (done !== 1'b1 && guard < 20) begin
      if (busy === 1'b1) ncyc++;
      guard++;
      @(negedge clk);
    end
    tmo = (done !== 1'b1);
  endtask

  task automatic sw_op(input int idx, input logic [31:0] ia, ib, input logic ici, imode,
                       output logic [31:0] osum, output logic oc, oo,
                       output int ncyc, output bit tmo);
    int guard;
    @(negedge clk);
    sa = ia; sb = ib; sci = ici; smode = imode; sst[idx] = 1'b1;
    @(negedge clk);
    sst[idx] = 1'b0;
    ncyc  = 0;
    guard = 0;
    while (sdone[idx] !== 1'b1 && guard < 40) begin
      if (sbusy[idx] === 1'b1) ncyc++;
      guard++;
      @(negedge clk);
    end
    tmo = (sdone[idx] !== 1'b1);
    case (idx)
      0:       osum = {28'd0, sum41};
      1:       osum = {28'd0, sum42};
      2:       osum = {28'd0, sum44};
      default: osum = sum328;
    endcase
    oc = scout[idx];
    oo = sovf[idx];
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b1; a = 16'hFFFF; b = 16'h0001; ci = 1'b1; mode = 1'b0;
    repeat (2) @(negedge clk);
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_tests++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b want 0", done); end
    n_tests++; if (sum !== 16'h0000) begin n_fail++; $display("FAIL reset_sum: got %h want 0000", sum); end
    n_tests++; if (cout !== 1'b0) begin n_fail++; $display("FAIL reset_cout: got %b want 0", cout); end
    n_tests++; if (ovf !== 1'b0) begin n_fail++; $display("FAIL reset_ovf: got %b want 0", ovf); end
    start = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    n_tests++; if (busy !== 1'b0 || done !== 1'b0) begin
      n_fail++; $display("FAIL reset_no_run: busy=%b done=%b want 0 0", busy, done);
    end
  endtask

  task automatic test_add();
    vec_t v [4];
    int   ncyc;
    bit   tmo;
    v[0] = '{16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0};
    v[1] = '{16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1};
    v[2] = '{16'h1234, 16'h0FFF, 1'b1, 1'b0, 16'h2234, 1'b0, 1'b0};
    v[3] = '{16'h8000, 16'h8000, 1'b1, 1'b0, 16'h0001, 1'b1, 1'b1};
    for (int i = 0; i < 4; i++) begin
      do_op(v[i].a, v[i].b, v[i].ci, v[i].mode, ncyc, tmo);
      n_tests++;
      if (tmo || ncyc !== 4 || sum !== v[i].s || cout !== v[i].c || ovf !== v[i].o) begin
        n_fail++;
        $display("FAIL add[%0d]: got sum=%h cout=%b ovf=%b busy_cycles=%0d timeout=%0b, want sum=%h cout=%b ovf=%b busy_cycles=4",
                 i, sum, cout, ovf, ncyc, tmo, v[i].s, v[i].c, v[i].o);
      end
      @(negedge clk);
      n_tests++;
      if (done !== 1'b0 || busy !== 1'b0) begin
        n_fail++; $display("FAIL add_pulse[%0d]: done=%b busy=%b want 0 0", i, done, busy);
      end
    end
  endtask

  task automatic test_sub();
    vec_t v [4];
    int   ncyc;
    bit   tmo;
    v[0] = '{16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1};
    v[1] = '{16'h0003, 16'h0005, 1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b0};
    v[2] = '{16'h0005, 16'h0003, 1'b1, 1'b1, 16'h0002, 1'b1, 1'b0};
    v[3] = '{16'h0000, 16'h0000, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0};
    for (int i = 0; i < 4; i++) begin
      do_op(v[i].a, v[i].b, v[i].ci, v[i].mode, ncyc, tmo);
      n_tests++;
      if (tmo || ncyc !== 4 || sum !== v[i].s || cout !== v[i].c || ovf !== v[i].o) begin
        n_fail++;
        $display("FAIL sub[%0d]: got sum=%h cout=%b ovf=%b busy_cycles=%0d timeout=%0b, want sum=%h cout=%b ovf=%b busy_cycles=4",
                 i, sum, cout, ovf, ncyc, tmo, v[i].s, v[i].c, v[i].o);
      end
    end
  endtask

  task automatic test_start_ignored();
    int ndone;
    logic [15:0] s_got;
    logic c_got, o_got;
    s_got = 16'hxxxx; c_got = 1'bx; o_got = 1'bx;
    @(negedge clk);
    a = 16'h1111; b = 16'h2222; ci = 1'b0; mode = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    a = 16'hFFFF; b = 16'hFFFF; mode = 1'b1; ci = 1'b1; start = 1'b1;
    @(negedge clk);
    start = 1'b0; a = 16'h0000; b = 16'h0000;
    ndone = 0;
    repeat (12) begin
      @(negedge clk);
      if (done === 1'b1) begin
        if (ndone == 0) begin s_got = sum; c_got = cout; o_got = ovf; end
        ndone++;
      end
    end
    n_tests++; if (ndone !== 1) begin n_fail++; $display("FAIL ignore_done_count: got %0d want 1", ndone); end
    n_tests++; if (s_got !== 16'h3333 || c_got !== 1'b0 || o_got !== 1'b0) begin
      n_fail++; $display("FAIL ignore_result: got sum=%h cout=%b ovf=%b want 3333 0 0", s_got, c_got, o_got);
    end
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL ignore_no_queue: busy=%b want 0", busy); end
  endtask

  task automatic test_reset_mid_run();
    int  ncyc;
    bit  tmo;
    bit  seen;
    do_op(16'h9000, 16'h8000, 1'b0, 1'b0, ncyc, tmo);
    n_tests++; if (tmo || sum !== 16'h1000 || cout !== 1'b1 || ovf !== 1'b1) begin
      n_fail++; $display("FAIL midrst_pre: got sum=%h cout=%b ovf=%b want 1000 1 1", sum, cout, ovf);
    end
    @(negedge clk);
    a = 16'h00FF; b = 16'h0F0F; ci = 1'b0; mode = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    n_tests++; if (busy !== 1'b0 || done !== 1'b0 || sum !== 16'h0000 || cout !== 1'b0 || ovf !== 1'b0) begin
      n_fail++; $display("FAIL midrst_clear: busy=%b done=%b sum=%h cout=%b ovf=%b want 0 0 0000 0 0",
                         busy, done, sum, cout, ovf);
    end
    seen = 1'b0;
    repeat (8) begin
      @(negedge clk);
      if (done !== 1'b0 || busy !== 1'b0) seen = 1'b1;
    end
    n_tests++; if (seen !== 1'b0) begin n_fail++; $display("FAIL midrst_no_done: activity=%b want 0", seen); end
    do_op(16'h1234, 16'h4321, 1'b0, 1'b0, ncyc, tmo);
    n_tests++; if (tmo || ncyc !== 4 || sum !== 16'h5555 || cout !== 1'b0 || ovf !== 1'b0) begin
      n_fail++; $display("FAIL midrst_after: got sum=%h cout=%b ovf=%b busy_cycles=%0d want 5555 0 0 4",
                         sum, cout, ovf, ncyc);
    end
  endtask

  task automatic test_back_to_back();
    vec_t v [4];
    int   guard;
    int   prev;
    v[0] = '{16'h0001, 16'h0002, 1'b0, 1'b0, 16'h0003, 1'b0, 1'b0};
    v[1] = '{16'hFFFF, 16'h0001, 1'b0, 1'b1, 16'hFFFE, 1'b1, 1'b0};
    v[2] = '{16'h4000, 16'h4000, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1};
    v[3] = '{16'h8000, 16'h7FFF, 1'b0, 1'b1, 16'h0001, 1'b1, 1'b1};
    prev = 0;
    @(negedge clk);
    a = v[0].a; b = v[0].b; ci = v[0].ci; mode = v[0].mode; start = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      n_tests++; if (busy !== 1'b1 || done !== 1'b0) begin
        n_fail++; $display("FAIL b2b_accept[%0d]: busy=%b done=%b want 1 0", i, busy, done);
      end
      if (i < 3) begin
        a = v[i+1].a; b = v[i+1].b; ci = v[i+1].ci; mode = v[i+1].mode;
      end else begin
        start = 1'b0;
      end
      guard = 0;
      while (done !== 1'b1 && guard < 20) begin
        @(negedge clk);
        guard++;
      end
      n_tests++;
      if (done !== 1'b1 || sum !== v[i].s || cout !== v[i].c || ovf !== v[i].o || (i > 0 && cyc - prev != 5)) begin
        n_fail++;
        $display("FAIL b2b[%0d]: got done=%b sum=%h cout=%b ovf=%b interval=%0d, want 1 %h %b %b interval=5",
                 i, done, sum, cout, ovf, cyc - prev, v[i].s, v[i].c, v[i].o);
      end
      prev = cyc;
    end
    @(negedge clk);
    n_tests++; if (done !== 1'b0 || busy !== 1'b0) begin
      n_fail++; $display("FAIL b2b_end: done=%b busy=%b want 0 0", done, busy);
    end
  endtask

  task automatic test_sweep_w4();
    logic [31:0] gs, es;
    logic        gc, go, ec, eo;
    int          ncyc, en;
    bit          tmo;
    for (int idx = 0; idx < 3; idx++) begin
      en = (idx == 0) ? 4 : (idx == 1) ? 2 : 1;
      for (int ia = 0; ia < 16; ia++)
        for (int ib = 0; ib < 16; ib++)
          for (int ic = 0; ic < 2; ic++)
            for (int im = 0; im < 2; im++) begin
              sw_op(idx, 32'(ia), 32'(ib), ic[0], im[0], gs, gc, go, ncyc, tmo);
              model(4, 32'(ia), 32'(ib), ic[0], im[0], es, ec, eo);
              n_tests++;
              if (tmo || gs !== es || gc !== ec || go !== eo || ncyc !== en) begin
                n_fail++;
                $display("FAIL sweep_w4[chunk_idx=%0d] a=%h b=%h ci=%0d mode=%0d: got %h %b %b cyc=%0d want %h %b %b cyc=%0d",
                         idx, ia, ib, ic, im, gs, gc, go, ncyc, es, ec, eo, en);
              end
            end
    end
  endtask

  task automatic test_sweep_w32();
    logic [31:0] va, vb, gs, es;
    logic        vc, vm, gc, go, ec, eo;
    int          ncyc;
    bit          tmo;
    for (int i = 0; i < 1000; i++) begin
      if (i == 0) begin
        va = 32'hFFFF_FFFF; vb = 32'h0000_0001; vc = 1'b0; vm = 1'b0;
      end else if (i == 1) begin
        va = 32'h8000_0000; vb = 32'h0000_0001; vc = 1'b0; vm = 1'b1;
      end else begin
        va = $urandom; vb = $urandom; vc = 1'($urandom_range(0, 1)); vm = 1'($urandom_range(0, 1));
      end
      sw_op(3, va, vb, vc, vm, gs, gc, go, ncyc, tmo);
      model(32, va, vb, vc, vm, es, ec, eo);
      n_tests++;
      if (tmo || gs !== es || gc !== ec || go !== eo || ncyc !== 4) begin
        n_fail++;
        $display("FAIL sweep_w32 a=%h b=%h ci=%b mode=%b: got %h %b %b cyc=%0d want %h %b %b cyc=4",
                 va, vb, vc, vm, gs, gc, go, ncyc, es, ec, eo);
      end
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; mode = 1'b0; ci = 1'b0; a = '0; b = '0;
    sst = '0; smode = 1'b0; sci = 1'b0; sa = '0; sb = '0;
    test_reset();
    test_add();
    test_sub();
    test_start_ignored();
    test_reset_mid_run();
    test_back_to_back();
    test_sweep_w4();
    test_sweep_w32();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not complete, tests=%0d failed=%0d", n_tests, n_fail);
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire
